debug_pulse_sweep: RTL and testbench

DEBUG_PULSE_SWEEP -- requirements
Module: debug_pulse_sweep

---
 rtl/debug_pulse_sweep.sv | 125 ++++++++++++
 tb/tb_debug_pulse_sweep.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/debug_pulse_sweep.sv
// debug_pulse_sweep: alternating idle/fire frames emitting per-channel hit pulses of swept, fixed or random width
// Optional build macro: DEBUG_PULSE_LFSR_EN adds the LFSR-driven random-width mode (mode 2).
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   enable        - freezes the frame counter and suppresses hits when low
//   hit_enable    - permits firing; fire frames without it do not advance anything
//   mode          - 0 sweep, 1 fixed, 2 random (macro) else sweep, 3 sweep; sampled at frame boundary
//   fixed_width   - pulse width in fixed mode; sampled at frame boundary
//   hit           - registered one-hot hit pulse on the current channel
//   finished      - sticky flag once SWEEPS full sweeps have completed
//   cur_width     - active compare value
//   cur_ch        - channel that fires in the next fire frame
module debug_pulse_sweep #(
    parameter int PERIOD = 240,
    parameter int NUM_CH = 1,
    parameter int SWEEPS = 3,
    parameter int STEP   = 1,
    localparam int CW    = $clog2(PERIOD + 2),
    localparam int CHW   = $clog2(NUM_CH + 1),
    localparam int SCW   = $clog2(SWEEPS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              hit_enable,
    input  logic [1:0]        mode,
    input  logic [CW-1:0]     fixed_width,
    output logic [NUM_CH-1:0] hit,
    output logic              finished,
    output logic [CW-1:0]     cur_width,
    output logic [CHW-1:0]    cur_ch
);
    logic [CW-1:0]     cnt_q, cnt_d, sw_q, sw_d, fix_q, fix_d, cur_w;
    logic              phase_q, phase_d, fired_q, fired_d, fin_q, fin_d;
    logic [1:0]        mode_q, mode_d;
    logic [CHW-1:0]    ch_q, ch_d;
    logic [SCW-1:0]    sc_q, sc_d;
    logic [NUM_CH-1:0] hit_q, hit_d;
    logic              boundary, fire_ok, end_fire, is_fixed, is_sweep, last_ch;

    assign boundary = enable && cnt_q == CW'(PERIOD);
    assign fire_ok  = phase_q && enable && hit_enable && !fin_q;
    // a fire frame counts as fired if firing was permitted in any of its cycles
    assign end_fire = boundary && phase_q && (fired_q || fire_ok);
    assign is_fixed = mode_q == 2'd1;
    assign last_ch  = ch_q == CHW'(NUM_CH - 1);

`ifdef DEBUG_PULSE_LFSR_EN
    logic [15:0] lfsr_q, lfsr_d;
    logic        is_rand;
    logic [CW-1:0] rnd_w;

    assign is_rand  = mode_q == 2'd2;
    assign is_sweep = !is_fixed && !is_rand;
    assign rnd_w    = CW'(32'(lfsr_q) % PERIOD + 1);
    assign cur_w    = is_fixed ? fix_q : is_rand ? rnd_w : sw_q;
    // x^16+x^14+x^13+x^11+1, stepped once at the end of each random-mode fire frame
    assign lfsr_d   = (boundary && phase_q && is_rand)
                    ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= '1;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign is_sweep = !is_fixed;
    assign cur_w    = is_fixed ? fix_q : sw_q;
`endif

    always_comb begin
        cnt_d   = enable ? (boundary ? '0 : cnt_q + 1'b1) : cnt_q;
        phase_d = boundary ? !phase_q : phase_q;
        mode_d  = boundary ? mode : mode_q;
        fix_d   = boundary ? fixed_width : fix_q;
        fired_d = boundary ? 1'b0 : (fired_q || fire_ok);
        hit_d   = (fire_ok && cnt_q < cur_w) ? NUM_CH'(1) << ch_q : '0;
        ch_d    = ch_q;
        sw_d    = sw_q;
        sc_d    = sc_q;
        fin_d   = fin_q;
        if (end_fire) begin
            ch_d = last_ch ? '0 : ch_q + 1'b1;
            if (is_sweep && last_ch) begin
                if (int'(sw_q) + STEP <= PERIOD) begin
                    sw_d = sw_q + CW'(STEP);
                end else begin
                    sw_d  = CW'(1);
                    sc_d  = sc_q + 1'b1;
                    fin_d = int'(sc_q) + 1 >= SWEEPS;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            mode_q  <= 2'd0;
            fix_q   <= '0;
            fired_q <= 1'b0;
            hit_q   <= '0;
            ch_q    <= '0;
            sw_q    <= CW'(1);
            sc_q    <= '0;
            fin_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            fix_q   <= fix_d;
            fired_q <= fired_d;
            hit_q   <= hit_d;
            ch_q    <= ch_d;
            sw_q    <= sw_d;
            sc_q    <= sc_d;
            fin_q   <= fin_d;
        end
    end

    assign hit       = hit_q;
    assign finished  = fin_q;
    assign cur_width = cur_w;
    assign cur_ch    = ch_q;
endmodule

// File: tb/tb_debug_pulse_sweep.sv
// tb_debug_pulse_sweep: directed table-driven bench for debug_pulse_sweep at PERIOD=7
module tb_debug_pulse_sweep;
    typedef struct {
        int w0;
        int ch1;
        int w1;
        int w2;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1, enable = 1'b1, hit_enable = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [3:0] fixed_width = 4'd0;
    logic [0:0] hit0, hit2, ch0, ch2;
    logic [2:0] hit1;
    logic [1:0] ch1;
    logic       fin0, fin1, fin2;
    logic [3:0] cw0, cw1, cw2;
    int total = 0, bad = 0, cyc = 0, fin_cyc = -1, c0 = 0, c2 = 0;
    int c1[3];
    vec_t tbl[16];

    debug_pulse_sweep #(.PERIOD(7), .NUM_CH(1), .SWEEPS(2), .STEP(1)) d0 (
        .clk(clk), .rst(rst), .enable(enable), .hit_enable(hit_enable), .mode(mode),
        .fixed_width(fixed_width), .hit(hit0), .finished(fin0), .cur_width(cw0), .cur_ch(ch0));
    debug_pulse_sweep #(.PERIOD(7), .NUM_CH(3), .SWEEPS(2), .STEP(1)) d1 (
        .clk(clk), .rst(rst), .enable(enable), .hit_enable(hit_enable), .mode(mode),
        .fixed_width(fixed_width), .hit(hit1), .finished(fin1), .cur_width(cw1), .cur_ch(ch1));
    debug_pulse_sweep #(.PERIOD(7), .NUM_CH(1), .SWEEPS(2), .STEP(3)) d2 (
        .clk(clk), .rst(rst), .enable(enable), .hit_enable(hit_enable), .mode(mode),
        .fixed_width(fixed_width), .hit(hit2), .finished(fin2), .cur_width(cw2), .cur_ch(ch2));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (fin0 && fin_cyc < 0) fin_cyc = cyc;
        c0 += int'(hit0);
        c2 += int'(hit2);
        for (int i = 0; i < 3; i++) c1[i] += int'(hit1[i]);
    endtask

    task automatic clear();
        c0 = 0;
        c2 = 0;
        for (int i = 0; i < 3; i++) c1[i] = 0;
    endtask

    task automatic pair();
        clear();
        repeat (16) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        fin_cyc = -1;
    endtask

    initial begin
        int lo, lf, ew;
        tbl = '{'{1,0,1,1}, '{2,1,1,4}, '{3,2,1,7}, '{4,0,2,1},
                '{5,1,2,4}, '{6,2,2,7}, '{7,0,3,0}, '{1,1,3,0},
                '{2,2,3,0}, '{3,0,4,0}, '{4,1,4,0}, '{5,2,4,0},
                '{6,0,5,0}, '{7,1,5,0}, '{0,2,5,0}, '{0,0,6,0}};
`ifdef DEBUG_PULSE_LFSR_EN
        mode = 2'd3;
`else
        mode = 2'd2;
`endif
        do_reset();
        check("rst_hit0", int'(hit0), 0);
        check("rst_fin0", int'(fin0), 0);
        check("rst_cw0", int'(cw0), 1);
        check("rst_ch1", int'(ch1), 0);
        check("rst_hit1", int'(hit1), 0);
        for (int j = 0; j < 16; j++) begin
            pair();
            check($sformatf("sweep%0d_w0", j), c0, tbl[j].w0);
            for (int k = 0; k < 3; k++)
                check($sformatf("sweep%0d_d1_ch%0d", j, k), c1[k], k == tbl[j].ch1 ? tbl[j].w1 : 0);
            check($sformatf("sweep%0d_w2", j), c2, tbl[j].w2);
            if (j == 2) check("step3_fin_after_one_sweep", int'(fin2), 0);
            if (j == 5) check("step3_fin_after_two_sweeps", int'(fin2), 1);
        end
        check("fin_rise_cycle", fin_cyc, 224);
        check("fin_sticky", int'(fin0), 1);
        rst = 1'b1;
        step();
        check("rst_after_fin_fin0", int'(fin0), 0);
        check("rst_after_fin_cw0", int'(cw0), 1);

        mode = 2'd0;
        do_reset();
        pair();
        check("fixed_pre_sweep_w", c0, 1);
        mode = 2'd1;
        fixed_width = 4'd0;
        pair();
        check("fixed_w0", c0, 0);
        fixed_width = 4'd3;
        pair();
        check("fixed_w3", c0, 3);
        fixed_width = 4'd9;
        clear();
        repeat (10) step();
        fixed_width = 4'd2;
        repeat (6) step();
        check("fixed_w9_midchange", c0, 8);
        pair();
        check("fixed_w2_next", c0, 2);
        check("fixed_fin", int'(fin0), 0);
        mode = 2'd0;
        pair();
        check("sweep_resume_w", c0, 2);

        mode = 2'd1;
        fixed_width = 4'd6;
        do_reset();
        clear();
        repeat (10) step();
        check("en_pre", c0, 2);
        enable = 1'b0;
        lo = 0;
        repeat (5) begin
            step();
            lo += int'(hit0);
        end
        check("en_low_hits", lo, 0);
        enable = 1'b1;
        clear();
        repeat (6) step();
        check("en_post", c0, 4);
        check("pre_rst_cw0", int'(cw0), 6);
        check("pre_rst_ch1", int'(ch1), 1);
        rst = 1'b1;
        step();
        check("midrst_cw0", int'(cw0), 1);
        check("midrst_ch1", int'(ch1), 0);
        check("midrst_hit", int'(hit0) + int'(hit1), 0);
        check("midrst_fin", int'(fin0), 0);

        mode = 2'd0;
        hit_enable = 1'b0;
        do_reset();
        pair();
        check("hiten_low_w", c0, 0);
        hit_enable = 1'b1;
        pair();
        check("hiten_resume_w", c0, 1);

`ifdef DEBUG_PULSE_LFSR_EN
        mode = 2'd2;
        do_reset();
        lf = 16'hffff;
        for (int j = 0; j < 6; j++) begin
            pair();
            ew = lf % 7 + 1;
            check($sformatf("rand%0d_w", j), c0, ew);
            lf = ((lf << 1) & 16'hfffe) | (((lf >> 15) ^ (lf >> 13) ^ (lf >> 12) ^ (lf >> 10)) & 1);
        end
        check("rand_fin", int'(fin0), 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
